// File: rtl/bip_pkg.sv
`default_nettype none
// ============================================================================
// Module : bip_pkg
// Brief  : Opcodes, select encodings, flag indices and multiplier FSM states
// Rev    : 1.0 - initial release
// ============================================================================
package bip_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SHL1 = 3'd5;
  localparam logic [2:0] OP_SRA1 = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  localparam logic [1:0] SELA_DM   = 2'd0;
  localparam logic [1:0] SELA_OPND = 2'd1;
  localparam logic [1:0] SELA_ALU  = 2'd2;
  localparam logic [1:0] SELA_HOLD = 2'd3;

  localparam logic SELB_OPND = 1'b0;
  localparam logic SELB_DM   = 1'b1;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage
`default_nettype wire

// File: rtl/bip_acc_datapath_if.sv
`default_nettype none
// ============================================================================
// Module : bip_acc_datapath_if
// Brief  : Control/data bundle between the sequencer and the accumulator path
// Rev    : 1.0 - initial release
// ============================================================================
interface bip_acc_datapath_if #(
  parameter int DATA_W = 16,
  parameter int OPND_W = 11
);
  logic [OPND_W-1:0] OPERAND_IN;
  logic [DATA_W-1:0] DM_IN;
  logic [1:0]        SEL_A;
  logic              SEL_B;
  logic              WR_ACC;
  logic [2:0]        OP;
  logic [DATA_W-1:0] ACC;
  logic [OPND_W-1:0] OPERAND_OUT;
  logic [3:0]        FLAGS;
  logic              BUSY;
  logic              DONE;

  modport master (
    output OPERAND_IN, DM_IN, SEL_A, SEL_B, WR_ACC, OP,
    input  ACC, OPERAND_OUT, FLAGS, BUSY, DONE
  );

  modport slave (
    input  OPERAND_IN, DM_IN, SEL_A, SEL_B, WR_ACC, OP,
    output ACC, OPERAND_OUT, FLAGS, BUSY, DONE
  );
endinterface
`default_nettype wire

// File: rtl/bip_seq_mul.sv
`default_nettype none
// ============================================================================
// Module : bip_seq_mul
// Brief  : Unsigned shift-add multiplier, one multiplier bit per RUN cycle
// Rev    : 1.0 - initial release
// ============================================================================
module bip_seq_mul
  import bip_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [DATA_W-1:0] mcand,
  input  logic [DATA_W-1:0] mplier,
  output logic              busy,
  output logic              done,
  output logic              finish,
  output logic [DATA_W-1:0] product,
  output logic              carry_hi
);

  localparam int CNT_W = $clog2(DATA_W);

  mul_state_t            r_state;
  mul_state_t            w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [2*DATA_W-1:0]   r_prod;
  logic [2*DATA_W-1:0]   r_mcand;
  logic [DATA_W-1:0]     r_mplier;
  logic [2*DATA_W-1:0]   w_prod_next;
  logic                  w_last;

  assign w_last      = (r_cnt == CNT_W'(DATA_W-1));
  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= MUL_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MUL_IDLE: if (start) w_next = MUL_RUN;
      MUL_RUN:  if (w_last) w_next = MUL_DONE;
      MUL_DONE: w_next = start ? MUL_RUN : MUL_IDLE;
      default:  w_next = MUL_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (r_state != MUL_RUN && start) begin
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mcand  <= {{DATA_W{1'b0}}, mcand};
      r_mplier <= mplier;
    end else if (r_state == MUL_RUN) begin
      r_cnt    <= r_cnt + 1'b1;
      r_prod   <= w_prod_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  // Final partial sum is forwarded combinationally so ACC loads on the RUN->DONE edge
  assign finish   = (r_state == MUL_RUN) && w_last;
  assign product  = w_prod_next[DATA_W-1:0];
  assign carry_hi = |w_prod_next[2*DATA_W-1:DATA_W];
  assign busy     = (r_state == MUL_RUN);
  assign done     = (r_state == MUL_DONE);

endmodule
`default_nettype wire

// File: rtl/bip_acc_datapath.sv
`default_nettype none
// ============================================================================
// Module : bip_acc_datapath
// Brief  : Accumulator, inline ALU/muxes and flags around a sequential multiplier
// Rev    : 1.0 - initial release
// ============================================================================
module bip_acc_datapath
  import bip_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int OPND_W   = 11,
  parameter int SIGN_EXT = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  bip_acc_datapath_if.slave bus
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] r_acc;
  logic [3:0]        r_flags;
  logic [DATA_W-1:0] w_ext, w_b, w_alu, w_wdata, w_mul_prod;
  logic [DATA_W:0]   w_sum;
  logic              w_alu_c, w_alu_v;
  logic              w_req, w_mul_start, w_write;
  logic              w_busy, w_done, w_mul_finish, w_mul_chi;

  generate
    if (SIGN_EXT != 0) begin : g_sext
      assign w_ext = {{(DATA_W-OPND_W){bus.OPERAND_IN[OPND_W-1]}}, bus.OPERAND_IN};
    end else begin : g_zext
      assign w_ext = {{(DATA_W-OPND_W){1'b0}}, bus.OPERAND_IN};
    end
  endgenerate

  assign w_b = (bus.SEL_B == SELB_DM) ? bus.DM_IN : w_ext;

  always_comb begin
    w_sum   = '0;
    w_alu   = '0;
    w_alu_c = 1'b0;
    w_alu_v = 1'b0;
    case (bus.OP)
      OP_ADD: begin
        w_sum   = {1'b0, r_acc} + {1'b0, w_b};
        w_alu   = w_sum[MSB:0];
        w_alu_c = w_sum[DATA_W];
        w_alu_v = (r_acc[MSB] == w_b[MSB]) && (w_alu[MSB] != r_acc[MSB]);
      end
      OP_SUB: begin
        // Carry out of A + ~B + 1 is the inverted borrow
        w_sum   = {1'b0, r_acc} + {1'b0, ~w_b} + {{DATA_W{1'b0}}, 1'b1};
        w_alu   = w_sum[MSB:0];
        w_alu_c = w_sum[DATA_W];
        w_alu_v = (r_acc[MSB] != w_b[MSB]) && (w_alu[MSB] != r_acc[MSB]);
      end
      OP_AND:  w_alu = r_acc & w_b;
      OP_OR:   w_alu = r_acc | w_b;
      OP_XOR:  w_alu = r_acc ^ w_b;
      OP_SHL1: begin
        w_alu   = {r_acc[MSB-1:0], 1'b0};
        w_alu_c = r_acc[MSB];
      end
      OP_SRA1: begin
        w_alu   = {r_acc[MSB], r_acc[MSB:1]};
        w_alu_c = r_acc[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_wdata = r_acc;
    case (bus.SEL_A)
      SELA_DM:   w_wdata = bus.DM_IN;
      SELA_OPND: w_wdata = w_ext;
      SELA_ALU:  w_wdata = w_alu;
      default:   w_wdata = r_acc;
    endcase
  end

  assign w_req       = bus.WR_ACC && (bus.SEL_A != SELA_HOLD) && !w_busy;
  assign w_mul_start = w_req && (bus.SEL_A == SELA_ALU) && (bus.OP == OP_MUL);
  assign w_write     = w_req && !w_mul_start;

  bip_seq_mul #(.DATA_W(DATA_W)) u_mul (
    .CLK      (CLK),
    .RESET    (RESET),
    .start    (w_mul_start),
    .mcand    (r_acc),
    .mplier   (w_b),
    .busy     (w_busy),
    .done     (w_done),
    .finish   (w_mul_finish),
    .product  (w_mul_prod),
    .carry_hi (w_mul_chi)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_acc   <= '0;
      r_flags <= '0;
    end else if (w_mul_finish) begin
      r_acc           <= w_mul_prod;
      r_flags[FLAG_Z] <= (w_mul_prod == '0);
      r_flags[FLAG_N] <= w_mul_prod[MSB];
      r_flags[FLAG_C] <= w_mul_chi;
      r_flags[FLAG_V] <= 1'b0;
    end else if (w_write) begin
      r_acc           <= w_wdata;
      r_flags[FLAG_Z] <= (w_wdata == '0);
      r_flags[FLAG_N] <= w_wdata[MSB];
      if (bus.SEL_A == SELA_ALU) begin
        r_flags[FLAG_C] <= w_alu_c;
        r_flags[FLAG_V] <= w_alu_v;
      end
    end
  end

  assign bus.ACC         = r_acc;
  assign bus.FLAGS       = r_flags;
  assign bus.BUSY        = w_busy;
  assign bus.DONE        = w_done;
  assign bus.OPERAND_OUT = bus.OPERAND_IN;

endmodule
`default_nettype wire

// File: doc/bip_acc_datapath.md
BIP_ACC_DATAPATH -- requirements
Module: bip_acc_datapath

Interface
REQ-001 The block SHALL take parameter DATA_W, default 16, as the accumulator, data-memory and ALU width.
REQ-002 The block SHALL take parameter OPND_W, default 11, as the instruction operand width, with OPND_W < DATA_W.
REQ-003 The block SHALL take parameter SIGN_EXT, default 0, selecting operand extension: 0 zero-extend, 1 sign-extend.
REQ-004 Port CLK, input, 1 bit: clock, rising-edge active.
REQ-005 Port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port OPERAND_IN, input, OPND_W bits: immediate/address field of the current instruction.
REQ-007 Port DM_IN, input, DATA_W bits: data-memory read value.
REQ-008 Port SEL_A, input, 2 bits: ACC source select (0 DM_IN, 1 extended operand, 2 ALU result, 3 hold).
REQ-009 Port SEL_B, input, 1 bit: ALU B select (0 extended operand, 1 DM_IN).
REQ-010 Port WR_ACC, input, 1 bit: ACC write enable.
REQ-011 Port OP, input, 3 bits: ALU opcode (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1, 6 SRA1, 7 MUL).
REQ-012 Port ACC, output, DATA_W bits: registered accumulator.
REQ-013 Port OPERAND_OUT, output, OPND_W bits: OPERAND_IN passed through combinationally.
REQ-014 Port FLAGS, output, 4 bits: registered {Z, N, C, V}.
REQ-015 Port BUSY, output, 1 bit: high while a multiply is in progress.
REQ-016 Port DONE, output, 1 bit: one-cycle pulse on the cycle the multiply result is visible on ACC.

Function
REQ-017 Extended operand SHALL be OPERAND_IN padded to DATA_W per SIGN_EXT.
REQ-018 ALU A SHALL be the registered ACC; ALU B SHALL be the SEL_B-selected value.
REQ-019 ADD/SUB SHALL be computed at DATA_W+1 bits; C = carry out (ADD) or NOT borrow (SUB); V = two's-complement overflow.
REQ-020 SHL1 SHALL set C to the bit shifted out; SRA1 SHALL replicate the MSB and set C to the old LSB; logic ops SHALL clear C and V.
REQ-021 Single-cycle writes (WR_ACC=1, SEL_A≠3, not MUL) SHALL update ACC on the next rising edge.
REQ-022 Z and N SHALL be updated from the written value on every ACC write; C and V SHALL be updated only on SEL_A=2 writes and held otherwise.
REQ-023 WR_ACC=0 or SEL_A=3 SHALL leave ACC and FLAGS unchanged.
REQ-024 WR_ACC=1, SEL_A=2, OP=7 while BUSY=0 SHALL start an unsigned shift-add multiply of ACC by B: operands are latched at the start edge and BUSY rises on that same edge.
REQ-025 The multiply FSM SHALL have states IDLE, RUN and DONE: IDLE→RUN on start; RUN lasts exactly DATA_W cycles, one multiplier bit per cycle; RUN→DONE writes the low DATA_W product bits to ACC; DONE→IDLE after one cycle.
REQ-026 Total MUL latency SHALL be DATA_W+1 edges from the start edge to the edge that writes ACC.
REQ-027 MUL SHALL set Z and N from the result, set C = OR of the discarded high product bits, and clear V.
REQ-028 BUSY SHALL be high in RUN and low in IDLE and DONE; DONE SHALL be high only in the DONE state.
REQ-029 All ACC write requests while BUSY=1 SHALL be ignored; a request on the DONE-pulse cycle SHALL be accepted normally.
REQ-030 A MUL request is a plain ALU request, so there SHALL be no queuing of a second MUL.

Reset
REQ-031 RESET=1 SHALL asynchronously force ACC=0, FLAGS=0, BUSY=0, DONE=0, FSM=IDLE and cycle counter=0.
REQ-032 RESET asserted during RUN SHALL abort the multiply with no ACC write; the next operation after release SHALL proceed normally.

Structure
REQ-033 The opcode constants, SEL_A/SEL_B encodings and FLAGS bit indices SHALL live in the shared package bip_pkg.
REQ-034 The multiplier SHALL be a separate sub-module, bip_seq_mul, with start/busy/done handshake; the ALU and muxes SHALL remain inline.

Verification (DATA_W=16, OPND_W=11)
REQ-035 RESET mid-run with ACC=0x1234 -> ACC=0, FLAGS=0, BUSY=0 immediately, without a clock.
REQ-036 Load ACC=0x7FFF, then ADD operand 1 -> ACC=0x8000, FLAGS N=1, V=1, C=0, Z=0.
REQ-037 SUB with DM_IN=0x0005 from ACC=0x0005 -> ACC=0, Z=1, C=1; with SIGN_EXT=1, loading operand 0x7FF -> ACC=0xFFFF.
REQ-038 Starting MUL with ACC=0x0012 and operand 0x0034 -> BUSY high for 16 cycles, ACC=0x03A8 on the 17th edge, DONE pulses once, C=0.
REQ-039 ADD issued while BUSY=1 -> ACC unchanged until the MUL result; MUL 0x0100×0x0100 -> ACC=0, Z=1, C=1.
REQ-040 RESET pulsed at RUN cycle 8 -> ACC=0, no DONE pulse; a following ADD of 3 -> ACC=0x0003.
